// File: rtl/ctrl_pipe_pkg.sv
// Shared defaults and control-word bit positions for the control pipeline.
package ctrl_pipe_pkg;

    localparam int unsigned DefCw     = 12;
    localparam int unsigned DefNs     = 3;
    localparam int unsigned DefKillSt = 0;

    localparam int unsigned RegWriteBit = 0;
    localparam int unsigned MemWriteBit = 1;
    localparam int unsigned MemToRegBit = 2;

    // A killed instruction must not update architectural state.
    localparam logic [DefCw-1:0] DefWeMask = (DefCw'(1) << RegWriteBit) |
                                             (DefCw'(1) << MemWriteBit);

    typedef enum logic [1:0] {
        SelLoad,
        SelHold,
        SelBubble
    } stageSel_e;

endpackage

// File: rtl/ctrl_stage_reg.sv
// One pipeline stage register: loads its source, holds, or takes a bubble.
module ctrl_stage_reg
    import ctrl_pipe_pkg::*;
#(
    parameter int unsigned CW = DefCw
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          hold,
    input  logic          bubble,
    input  logic [CW-1:0] srcCtrl,
    input  logic          srcValid,
    output logic [CW-1:0] ctrl,
    output logic          valid
);

    stageSel_e sel;

    always_comb begin
        sel = SelLoad;
        if (flush) begin
            sel = SelBubble;
        end else if (hold) begin
            sel = SelHold;
        end else if (bubble) begin
            sel = SelBubble;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl  <= '0;
            valid <= 1'b0;
        end else begin
            unique case (sel)
                SelLoad: begin
                    ctrl  <= srcCtrl;
                    valid <= srcValid;
                end
                SelBubble: begin
                    ctrl  <= '0;
                    valid <= 1'b0;
                end
                SelHold: begin
                    ctrl  <= ctrl;
                    valid <= valid;
                end
            endcase
        end
    end

endmodule

// File: rtl/ctrl_pipe.sv
// Control-word pipeline after decode, with an exception kill that strips the
// write enables from the faulting instruction and a sticky/counted exception record.
module ctrl_pipe
    import ctrl_pipe_pkg::*;
#(
    parameter int unsigned    CW      = DefCw,
    parameter int unsigned    NS      = DefNs,
    parameter int unsigned    KILL_ST = DefKillSt,
    parameter logic [CW-1:0]  WE_MASK = DefWeMask
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CW-1:0]    ctrl_d,
    input  logic             valid_d,
    input  logic [NS-1:0]    stall,
    input  logic [NS-1:0]    flush,
    input  logic             exc_kill,
    input  logic             exc_ack,
    output logic [NS*CW-1:0] ctrl_q,
    output logic [NS-1:0]    valid_q,
    output logic             exc_pending,
    output logic [7:0]       kill_cnt
);

    logic [CW-1:0] stCtrl [NS];
    logic          killXfer;

    // The killed word must really move into the next stage, otherwise the
    // source keeps exc_kill high and we act once the transfer happens.
    assign killXfer = exc_kill && valid_q[KILL_ST] && !stall[KILL_ST] &&
                      !stall[KILL_ST+1] && !flush[KILL_ST+1];

    for (genvar i = 0; i < NS; i++) begin : gStage
        logic [CW-1:0] srcCtrl;
        logic          srcValid;
        logic          bubble;

        if (i == 0) begin : gFirst
            assign srcCtrl  = ctrl_d;
            assign srcValid = valid_d;
            assign bubble   = 1'b0;
        end else if (i == KILL_ST + 1) begin : gKill
            assign srcCtrl  = killXfer ? (stCtrl[i-1] & ~WE_MASK) : stCtrl[i-1];
            assign srcValid = valid_q[i-1];
            assign bubble   = stall[i-1];
        end else begin : gPlain
            assign srcCtrl  = stCtrl[i-1];
            assign srcValid = valid_q[i-1];
            assign bubble   = stall[i-1];
        end

        ctrl_stage_reg #(
            .CW(CW)
        ) uStage (
            .clk     (clk),
            .rst     (rst),
            .flush   (flush[i]),
            .hold    (stall[i]),
            .bubble  (bubble),
            .srcCtrl (srcCtrl),
            .srcValid(srcValid),
            .ctrl    (stCtrl[i]),
            .valid   (valid_q[i])
        );

        assign ctrl_q[i*CW +: CW] = stCtrl[i];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exc_pending <= 1'b0;
            kill_cnt    <= '0;
        end else begin
            if (killXfer) begin
                exc_pending <= 1'b1;
            end else if (exc_ack) begin
                exc_pending <= 1'b0;
            end
            if (killXfer && kill_cnt != 8'hFF) begin
                kill_cnt <= kill_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed self-checking bench for ctrl_pipe at default parameters.
module tb_ctrl_pipe;

    logic        clk;
    logic        rst;
    logic [11:0] ctrl_d;
    logic        valid_d;
    logic [2:0]  stall;
    logic [2:0]  flush;
    logic        exc_kill;
    logic        exc_ack;
    logic [35:0] ctrl_q;
    logic [2:0]  valid_q;
    logic        exc_pending;
    logic [7:0]  kill_cnt;

    int nChecks = 0;
    int nPass   = 0;

    ctrl_pipe dut (
        .clk        (clk),
        .rst        (rst),
        .ctrl_d     (ctrl_d),
        .valid_d    (valid_d),
        .stall      (stall),
        .flush      (flush),
        .exc_kill   (exc_kill),
        .exc_ack    (exc_ack),
        .ctrl_q     (ctrl_q),
        .valid_q    (valid_q),
        .exc_pending(exc_pending),
        .kill_cnt   (kill_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got === exp) begin
            nPass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] stg(input int i);
        return ctrl_q[i*12 +: 12];
    endfunction

    // Inputs change 1 time unit after the edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        valid_d = 1'b0;
        ctrl_d  = '0;
        repeat (3) tick();
    endtask

    initial begin
        rst = 1'b1; ctrl_d = '0; valid_d = 1'b0; stall = '0; flush = '0;
        exc_kill = 1'b0; exc_ack = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        check("reset ctrl_q", 32'(ctrl_q), 32'h0);
        check("reset valid_q", 32'(valid_q), 32'h0);
        check("reset exc_pending", 32'(exc_pending), 32'h0);
        check("reset kill_cnt", 32'(kill_cnt), 32'h0);

        // Free flow
        ctrl_d = 12'hA5F; valid_d = 1'b1;
        tick();
        check("flow st0", 32'(stg(0)), 32'hA5F);
        check("flow valid c1", 32'(valid_q), 32'b001);
        valid_d = 1'b0; ctrl_d = '0;
        tick();
        check("flow st1", 32'(stg(1)), 32'hA5F);
        check("flow valid c2", 32'(valid_q), 32'b010);
        tick();
        check("flow st2", 32'(stg(2)), 32'hA5F);
        check("flow valid c3", 32'(valid_q), 32'b100);
        tick();
        check("flow empty", 32'(valid_q), 32'b000);

        // Stall bubble in stage 1 while stage 0 holds
        ctrl_d = 12'h123; valid_d = 1'b1;
        tick();
        valid_d = 1'b0; ctrl_d = '0; stall = 3'b001;
        for (int c = 0; c < 2; c++) begin
            tick();
            check("stall st0 hold", 32'(stg(0)), 32'h123);
            check("stall st1 bubble ctrl", 32'(stg(1)), 32'h0);
            check("stall valid", 32'(valid_q), 32'b001);
        end
        stall = 3'b000;
        tick();
        check("release st1", 32'(stg(1)), 32'h123);
        check("release valid", 32'(valid_q), 32'b010);
        tick();
        check("release st2", 32'(stg(2)), 32'h123);
        check("release no dup", 32'(valid_q), 32'b100);
        drain();

        // Kill
        ctrl_d = 12'hFFF; valid_d = 1'b1;
        tick();
        valid_d = 1'b0; ctrl_d = '0; exc_kill = 1'b1;
        tick();
        exc_kill = 1'b0;
        check("kill st1", 32'(stg(1)), 32'hFFC);
        check("kill valid", 32'(valid_q), 32'b010);
        check("kill pending", 32'(exc_pending), 32'h1);
        check("kill cnt", 32'(kill_cnt), 32'd1);
        exc_ack = 1'b1;
        tick();
        exc_ack = 1'b0;
        check("ack pending", 32'(exc_pending), 32'h0);
        check("ack st2", 32'(stg(2)), 32'hFFC);
        drain();

        // Kill held off by a downstream stall
        ctrl_d = 12'hABF; valid_d = 1'b1;
        tick();
        valid_d = 1'b0; ctrl_d = '0; exc_kill = 1'b1; stall = 3'b011;
        for (int c = 0; c < 2; c++) begin
            tick();
            check("kstall st0", 32'(stg(0)), 32'hABF);
            check("kstall valid", 32'(valid_q), 32'b001);
            check("kstall cnt", 32'(kill_cnt), 32'd1);
            check("kstall pending", 32'(exc_pending), 32'h0);
        end
        stall = 3'b000;
        tick();
        check("kstall release st1", 32'(stg(1)), 32'hABC);
        check("kstall release cnt", 32'(kill_cnt), 32'd2);
        check("kstall release pending", 32'(exc_pending), 32'h1);
        tick();
        check("kstall single count", 32'(kill_cnt), 32'd2);
        exc_kill = 1'b0; exc_ack = 1'b1;
        tick();
        exc_ack = 1'b0;
        check("kstall ack", 32'(exc_pending), 32'h0);
        drain();

        // Kill colliding with flush of the destination stage
        ctrl_d = 12'hFFF; valid_d = 1'b1;
        tick();
        valid_d = 1'b0; ctrl_d = '0; exc_kill = 1'b1; flush = 3'b010;
        tick();
        exc_kill = 1'b0; flush = 3'b000;
        check("collide st1 ctrl", 32'(stg(1)), 32'h0);
        check("collide valid", 32'(valid_q), 32'b000);
        check("collide cnt", 32'(kill_cnt), 32'd2);
        check("collide pending", 32'(exc_pending), 32'h0);
        drain();

        // Saturation; exc_ack held throughout so set must win
        ctrl_d = 12'hFFF; valid_d = 1'b1; exc_kill = 1'b1; exc_ack = 1'b1;
        repeat (300) tick();
        check("sat cnt", 32'(kill_cnt), 32'd255);
        check("sat pending set wins", 32'(exc_pending), 32'h1);
        check("sat valid", 32'(valid_q), 32'b111);
        check("sat st1", 32'(stg(1)), 32'hFFC);
        check("sat st2", 32'(stg(2)), 32'hFFC);

        // Reset mid-flight overrides stall and kill
        exc_ack = 1'b0; rst = 1'b1; stall = 3'b111;
        tick();
        rst = 1'b0; stall = 3'b000; exc_kill = 1'b0;
        check("rst ctrl_q", 32'(ctrl_q), 32'h0);
        check("rst valid_q", 32'(valid_q), 32'h0);
        check("rst pending", 32'(exc_pending), 32'h0);
        check("rst cnt", 32'(kill_cnt), 32'h0);
        ctrl_d = 12'h5A5; valid_d = 1'b1;
        tick();
        valid_d = 1'b0; ctrl_d = '0;
        check("post rst st0", 32'(stg(0)), 32'h5A5);
        tick();
        check("post rst st1", 32'(stg(1)), 32'h5A5);
        tick();
        check("post rst st2", 32'(stg(2)), 32'h5A5);
        check("post rst valid", 32'(valid_q), 32'b100);
        check("post rst cnt", 32'(kill_cnt), 32'h0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe.md
CTRL_PIPE -- requirements
Module: ctrl_pipe

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; the ports SHALL be named clk and rst.
REQ-002 Parameter CW, default 12: control-word width in bits.
REQ-003 Parameter NS, default 3: number of pipeline stages after decode (index 0 = Execute).
REQ-004 Parameter KILL_ST, default 0: index of the stage where an exception kill is applied; legal range 0..NS-2.
REQ-005 Parameter WE_MASK, default 12'h003: control bits forced to 0 on a kill (the regwrite and memwrite bits).
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 ctrl_d  in  CW  decoded control word from the decode stage.
REQ-009 valid_d  in  1  ctrl_d carries a real instruction.
REQ-010 stall  in  NS  stall[i] holds stage i.
REQ-011 flush  in  NS  flush[i] loads a bubble into stage i.
REQ-012 exc_kill  in  1  exception (e.g. overflow) on the instruction in stage KILL_ST.
REQ-013 exc_ack  in  1  clears exc_pending.
REQ-014 ctrl_q  out  NS*CW  stage i word at bits [i*CW +: CW].
REQ-015 valid_q  out  NS  per-stage valid bit.
REQ-016 exc_pending  out  1  sticky flag: a kill has occurred and has not been acknowledged.
REQ-017 kill_cnt  out  8  saturating count of killed instructions.

Function
REQ-018 Stage i SHALL take its source from stage i-1; the source for stage 0 SHALL be {valid_d, ctrl_d}.
REQ-019 Per-stage update priority SHALL be, highest first: rst, then flush[i] (bubble), then stall[i] (hold), then advance.
REQ-020 A bubble SHALL be valid=0 with ctrl=0.
REQ-021 For i>=1, when stall[i]=0 and stall[i-1]=1, stage i SHALL load a bubble so the held instruction is not duplicated.
REQ-022 Stage 0 SHALL load the source word regardless of stall on any upstream stage; decode-stage stalling is handled outside this block.
REQ-023 A kill transfer SHALL occur when all of the following hold: exc_kill=1, valid_q[KILL_ST]=1, stall[KILL_ST]=0, stall[KILL_ST+1]=0 and flush[KILL_ST+1]=0.
REQ-024 On a kill transfer, stage KILL_ST+1 SHALL load ctrl & ~WE_MASK with valid=1.
REQ-025 When exc_kill=1 but no kill transfer occurs, the block SHALL take no kill action; the source keeps exc_kill asserted while the instruction is held.
REQ-026 exc_pending SHALL set one cycle after a kill transfer and clear one cycle after exc_ack=1; if set and clear coincide, set SHALL win.
REQ-027 kill_cnt SHALL increment by 1 per kill transfer and saturate at 255.
REQ-028 Outputs SHALL be registered, with latency 1 cycle per stage: a word presented at cycle t appears in stage i at cycle t+i+1 when there is no stall or flush.
REQ-029 A flush[i] coinciding with a kill into stage i SHALL yield a bubble, and kill_cnt and exc_pending SHALL be unchanged.

Reset
REQ-030 On rst=1 at a clock edge, every ctrl_q, every valid_q, exc_pending and kill_cnt SHALL be 0 after that edge.
REQ-031 Reset SHALL override stall, flush and exc_kill in the same cycle.
REQ-032 An instruction in flight when reset asserts SHALL be discarded and SHALL NOT be counted.

Structure
REQ-033 Package ctrl_pipe_pkg SHALL hold the default CW, NS, KILL_ST and WE_MASK values and the bit indices of the regwrite, memwrite and memtoreg bits.
REQ-034 Sub-module ctrl_stage_reg SHALL implement one stage (data, valid, flush, hold, bubble-select) and SHALL be instantiated NS times by generate.
REQ-035 The kill logic and the counters SHALL reside in the top level.

Verification (CW=12, NS=3, KILL_ST=0, WE_MASK=12'h003)
REQ-036 Free flow: ctrl_d=12'hA5F, valid_d=1 at cycle 0 -> ctrl_q stage0 = A5F at cycle 1, stage1 at cycle 2, stage2 at cycle 3, with valid_q set accordingly.
REQ-037 Stall bubble: stall=3'b001 for 2 cycles with 12'h123 in stage 0 -> stage 0 holds 123 and stage 1 shows bubbles (valid=0, ctrl=0) on both cycles -> 123 reaches stage 1 exactly once after release.
REQ-038 Kill: 12'hFFF in stage 0 with exc_kill=1 -> stage 1 = 12'hFFC with valid=1, exc_pending=1 and kill_cnt=1 one cycle later; exc_ack=1 -> exc_pending=0 the following cycle.
REQ-039 Kill during stall: exc_kill=1 with stall[1]=1 -> no change to stages 0/1 counters; release with exc_kill still 1 -> exactly one kill counted.
REQ-040 Saturation and collision: 256 kill transfers -> kill_cnt=255; a kill plus flush[1] in the same cycle -> stage 1 is a bubble and the count is unchanged.
REQ-041 Reset mid-flight: rst=1 with all stages valid and exc_pending=1 -> all outputs 0 the next cycle; the first word after reset flows normally.
